// File: rtl/obsidian_pkg.sv
// ============================================================================
// Module   : obsidian_pkg
// Purpose  : Shared types and constants for the ALU arbiter slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

package obsidian_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int OP_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Shift and AND occupy code ranges; the low bits pick the variant.
    localparam logic [OP_W-1:0] ALU_ADD   = 4'b0000;
    localparam logic [OP_W-1:0] ALU_SUB   = 4'b0001;
    localparam logic [OP_W-1:0] ALU_OR    = 4'b0010;
    localparam logic [OP_W-1:0] ALU_XOR   = 4'b0011;
    localparam logic [OP_W-1:0] ALU_SHIFT = 4'b0100;
    localparam logic [OP_W-1:0] ALU_AND   = 4'b1000;

endpackage

`default_nettype wire

// File: rtl/obsidian_alu_arbiter_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin priority picker scanning upward from last_i+1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    logic [ID_W:0] cand;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_i} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req_i[cand[ID_W-1:0]]) begin
                found = 1'b1;
                idx_o = cand[ID_W-1:0];
            end
        end
        // Index is always computed; only the grant vector is gated.
        if (en_i && found) begin
            gnt_o[idx_o] = 1'b1;
        end
        any_o = found;
    end

endmodule

`default_nettype wire

// File: rtl/obsidian_alu_arbiter.sv
// ============================================================================
// Module   : obsidian_alu_arbiter
// Purpose  : Shares one combinational ALU between NUM_REQ requesters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module obsidian_alu_arbiter
    import obsidian_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [OP_W*NUM_REQ-1:0]   req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    input  logic [SHAMT_W*NUM_REQ-1:0] req_shamt,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [OP_W-1:0]           alu_control,
    output logic [SHAMT_W-1:0]        alu_shamt,
    input  logic [DATA_W-1:0]         alu_c,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy
);

    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

    state_t               state_q, state_d;
    logic [ID_W-1:0]      last_grant_q, last_grant_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [DATA_W-1:0]    alu_a_q, alu_a_d;
    logic [DATA_W-1:0]    alu_b_q, alu_b_d;
    logic [OP_W-1:0]      alu_op_q, alu_op_d;
    logic [SHAMT_W-1:0]   alu_sh_q, alu_sh_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;

    logic                 grant_en;
    logic                 win_any;
    logic                 do_grant;
    logic [ID_W-1:0]      win_idx;
    logic [NUM_REQ-1:0]   gnt;

    logic [OP_W-1:0]      op_v    [NUM_REQ];
    logic [DATA_W-1:0]    a_v     [NUM_REQ];
    logic [DATA_W-1:0]    b_v     [NUM_REQ];
    logic [SHAMT_W-1:0]   shamt_v [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_v[i]    = req_op[OP_W*i +: OP_W];
        assign a_v[i]     = req_a[DATA_W*i +: DATA_W];
        assign b_v[i]     = req_b[DATA_W*i +: DATA_W];
        assign shamt_v[i] = req_shamt[SHAMT_W*i +: SHAMT_W];
    end

    // A new grant may overlap the response handshake that frees the slot.
    assign grant_en = (state_q == IDLE) ||
                      ((state_q == RESP) && rsp_valid_q && rsp_ready);
    assign do_grant = grant_en && win_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i  (req_valid),
        .last_i (last_grant_q),
        .en_i   (grant_en),
        .gnt_o  (gnt),
        .idx_o  (win_idx),
        .any_o  (win_any)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        alu_sh_d     = alu_sh_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;

        case (state_q)
            IDLE: begin
                if (do_grant) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_c;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = do_grant ? EXEC : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_grant) begin
            alu_a_d      = a_v[win_idx];
            alu_b_d      = b_v[win_idx];
            alu_op_d     = op_v[win_idx];
            alu_sh_d     = shamt_v[win_idx];
            last_grant_d = win_idx;
            id_d         = win_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_RST;
            id_q         <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            alu_sh_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            alu_sh_q     <= alu_sh_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign req_ready   = gnt;
    assign busy        = (state_q != IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_op_q;
    assign alu_shamt   = alu_sh_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_id      = rsp_id_q;

endmodule

`default_nettype wire

// File: tb/tb_obsidian_alu_arbiter.sv
// ============================================================================
// Module   : tb_obsidian_alu_arbiter
// Purpose  : Directed self-checking bench with a behavioural ALU on alu_c.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_obsidian_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [9:0]  req_shamt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_c;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [0:0]  rsp_id;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    obsidian_alu_arbiter #(
        .NUM_REQ (2),
        .ID_W    (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_shamt   (req_shamt),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_shamt   (alu_shamt),
        .alu_c       (alu_c),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU standing in for the shared datapath.
    always_comb begin
        alu_c = 32'h0;
        casez (alu_control)
            4'b0000: alu_c = alu_a + alu_b;
            4'b0001: alu_c = alu_a - alu_b;
            4'b0010: alu_c = alu_a | alu_b;
            4'b0011: alu_c = alu_a ^ alu_b;
            4'b0100: alu_c = alu_a << alu_shamt;
            4'b0101: alu_c = alu_a >> alu_shamt;
            4'b011?: alu_c = $unsigned($signed(alu_a) >>> alu_shamt);
            4'b1???: alu_c = alu_a & alu_b;
            default: alu_c = 32'h0;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh);
        req_op[idx*4 +: 4]    = op;
        req_a[idx*32 +: 32]   = a;
        req_b[idx*32 +: 32]   = b;
        req_shamt[idx*5 +: 5] = sh;
    endtask

    // Issue one op from requester idx with rsp_ready high; called at a negedge in IDLE.
    task automatic single_op(input int idx, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
        set_req(idx, op, a, b, sh);
        req_valid = 2'(1 << idx);
        rsp_ready = 1'b1;
        #1;
        check_eq("grant_ready", 32'(req_ready), 32'(1 << idx));
        @(negedge clk);
        req_valid = 2'b00;
        check_eq("exec_ready", 32'(req_ready), 32'h0);
        check_eq("exec_busy", 32'(busy), 32'h1);
        check_eq("exec_alu_a", alu_a, a);
        check_eq("exec_alu_b", alu_b, b);
        check_eq("exec_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        check_eq("rsp_valid", 32'(rsp_valid), 32'h1);
        check_eq("rsp_data", rsp_data, exp);
        check_eq("rsp_id", 32'(rsp_id), 32'(idx));
        @(negedge clk);
        check_eq("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("idle_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_shamt = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_rsp_data", rsp_data, 32'h0);
        check_eq("rst_rsp_id", 32'(rsp_id), 32'h0);
        check_eq("rst_alu_a", alu_a, 32'h0);
        check_eq("rst_alu_ctl", 32'(alu_control), 32'h0);
        rst = 1'b0;

        // Single ops: add, subtract wrap, AND, logical right shift
        @(negedge clk);
        single_op(0, 4'b0000, 32'd5, 32'd7, 5'd0, 32'd12);
        single_op(0, 4'b0001, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE);
        single_op(1, 4'b1000, 32'hFFFF_0000, 32'h1234_5678, 5'd0, 32'h1234_0000);
        single_op(1, 4'b0101, 32'h8000_0000, 32'h0, 5'd4, 32'h0800_0000);

        // Round-robin with both requesters continuously valid
        set_req(0, 4'b0011, 32'h0000_F0F0, 32'h0000_0FF0, 5'd0);
        set_req(1, 4'b0010, 32'h1, 32'h2, 5'd0);
        req_valid = 2'b11;
        #1;
        check_eq("rr_first_ready", 32'(req_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("rr_exec_ready", 32'(req_ready), 32'h0);
            check_eq("rr_exec_valid", 32'(rsp_valid), 32'h0);
            @(negedge clk);
            check_eq("rr_rsp_valid", 32'(rsp_valid), 32'h1);
            check_eq("rr_rsp_id", 32'(rsp_id), 32'(i % 2));
            check_eq("rr_rsp_data", rsp_data, (i % 2 == 0) ? 32'h0000_FF00 : 32'h3);
            check_eq("rr_next_ready", 32'(req_ready), (i % 2 == 0) ? 32'h2 : 32'h1);
        end
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("rr_idle_busy", 32'(busy), 32'h0);

        // Backpressure: response held while req1 waits
        set_req(0, 4'b0000, 32'd100, 32'd1, 5'd0);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        #1;
        check_eq("bp_grant0", 32'(req_ready), 32'h1);
        @(negedge clk);
        set_req(1, 4'b0001, 32'd10, 32'd4, 5'd0);
        req_valid = 2'b10;
        check_eq("bp_exec_ready", 32'(req_ready), 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("bp_hold_valid", 32'(rsp_valid), 32'h1);
            check_eq("bp_hold_data", rsp_data, 32'd101);
            check_eq("bp_hold_id", 32'(rsp_id), 32'h0);
            check_eq("bp_hold_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("bp_same_cycle_grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = 2'b00;
        check_eq("bp_exec_valid", 32'(rsp_valid), 32'h0);
        check_eq("bp_exec_busy", 32'(busy), 32'h1);
        check_eq("bp_exec_alu_a", alu_a, 32'd10);
        @(negedge clk);
        check_eq("bp_rsp2_valid", 32'(rsp_valid), 32'h1);
        check_eq("bp_rsp2_data", rsp_data, 32'd6);
        check_eq("bp_rsp2_id", 32'(rsp_id), 32'h1);
        @(negedge clk);
        check_eq("bp_idle_busy", 32'(busy), 32'h0);

        // Reset while in EXEC
        set_req(0, 4'b0000, 32'd2, 32'd2, 5'd0);
        req_valid = 2'b01;
        #1;
        check_eq("mr_grant0", 32'(req_ready), 32'h1);
        @(negedge clk);
        check_eq("mr_exec_busy", 32'(busy), 32'h1);
        req_valid = 2'b00;
        rst = 1'b1;
        #1;
        check_eq("mr_async_valid", 32'(rsp_valid), 32'h0);
        check_eq("mr_async_busy", 32'(busy), 32'h0);
        check_eq("mr_async_alu_a", alu_a, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("mr_no_rsp", 32'(rsp_valid), 32'h0);
            check_eq("mr_idle", 32'(busy), 32'h0);
        end
        set_req(1, 4'b0000, 32'd9, 32'd9, 5'd0);
        req_valid = 2'b11;
        #1;
        check_eq("mr_first_is_req0", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        check_eq("mr_exec_alu_a", alu_a, 32'd2);
        @(negedge clk);
        check_eq("mr_rsp_data", rsp_data, 32'd4);
        check_eq("mr_rsp_id", 32'(rsp_id), 32'h0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
